// File: rtl/board_memory.sv
// Connect Four board storage: combinational cell read, column drops driven by
// per-column height counters, winning-marker write-back and a row-by-row clear sweep.
module board_memory #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       drop_valid,
    output logic       drop_ready,
    input  logic [2:0] drop_col,
    input  logic [1:0] drop_player,
    output logic       drop_done,
    output logic       drop_ok,
    output logic [2:0] drop_row,
    output logic [2:0] drop_col_q,
    input  logic [2:0] read_row,
    input  logic [2:0] read_col,
    output logic [1:0] data_out,
    input  logic       win_we,
    input  logic [2:0] win_row,
    input  logic [2:0] win_col,
    output logic       board_full,
    output logic       busy
);

    // Height must be able to hold ROWS itself (saturation value), hence the +1.
    localparam int HW  = $clog2(ROWS + 1);
    localparam int MCW = $clog2(ROWS * COLS + 1);

    localparam logic [3:0]     ROWS_L   = 4'(ROWS);
    localparam logic [3:0]     COLS_L   = 4'(COLS);
    localparam logic [HW-1:0]  ROWS_H   = HW'(ROWS);
    localparam logic [MCW-1:0] MC_FULL  = MCW'(ROWS * COLS);
    localparam logic [2:0]     LAST_ROW = 3'(ROWS - 1);

    // Handshake: a drop is taken at a rising edge where drop_valid & drop_ready
    // are both high and clear is low; its result appears one cycle later as a
    // single-cycle drop_done pulse, qualified by drop_ok.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Storage spans the full 3-bit address space so any coordinate indexes safely;
    // cells outside ROWS x COLS are never written and never reach data_out.
    logic [1:0]     cells  [8][8];
    logic [HW-1:0]  height [8];
    logic [MCW-1:0] move_count;
    logic [2:0]     sweep_idx;

    logic           start_clear;
    logic           drop_fire;
    logic           drop_accept;
    logic           win_en;
    logic [HW-1:0]  height_sel;
    logic [2:0]     land_row;
    logic [MCW-1:0] mc_next;

    always_comb begin
        state_d     = state_q;
        drop_ready  = 1'b0;
        busy        = 1'b0;
        start_clear = 1'b0;
        win_en      = 1'b0;
        case (state_q)
            IDLE: begin
                drop_ready = 1'b1;
                if (clear) begin
                    state_d     = CLEAR;
                    start_clear = 1'b1;
                end else begin
                    win_en = win_we && ({1'b0, win_row} < ROWS_L) && ({1'b0, win_col} < COLS_L);
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (sweep_idx == LAST_ROW) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        height_sel  = height[drop_col];
        land_row    = 3'(height_sel);
        mc_next     = move_count + MCW'(1);
        drop_fire   = drop_valid && drop_ready && !clear;
        drop_accept = drop_fire
                      && ({1'b0, drop_col} < COLS_L)
                      && (height_sel != ROWS_H)
                      && (drop_player == 2'b01 || drop_player == 2'b10);
    end

    always_comb begin
        data_out = 2'b00;
        if (({1'b0, read_row} < ROWS_L) && ({1'b0, read_col} < COLS_L)) begin
            data_out = cells[read_row][read_col];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    cells[r][c] <= 2'b00;
                end
            end
            for (int c = 0; c < 8; c++) begin
                height[c] <= '0;
            end
            move_count <= '0;
            sweep_idx  <= '0;
            board_full <= 1'b0;
            drop_done  <= 1'b0;
            drop_ok    <= 1'b0;
            drop_row   <= '0;
            drop_col_q <= '0;
        end else begin
            drop_done <= 1'b0;

            if (start_clear) begin
                for (int c = 0; c < 8; c++) begin
                    height[c] <= '0;
                end
                move_count <= '0;
                board_full <= 1'b0;
                sweep_idx  <= '0;
            end

            if (state_q == CLEAR) begin
                for (int c = 0; c < 8; c++) begin
                    cells[sweep_idx][c] <= 2'b00;
                end
                sweep_idx <= sweep_idx + 3'd1;
            end

            if (drop_fire) begin
                drop_done  <= 1'b1;
                drop_ok    <= drop_accept;
                drop_row   <= drop_accept ? land_row : 3'd0;
                drop_col_q <= drop_col;
                if (drop_accept) begin
                    cells[land_row][drop_col] <= drop_player;
                    height[drop_col]          <= height_sel + HW'(1);
                    move_count                <= mc_next;
                    board_full                <= (mc_next == MC_FULL);
                end
            end

            // Placed after the drop write so the marker wins on a shared cell.
            if (win_en) begin
                cells[win_row][win_col] <= 2'b11;
            end
        end
    end

endmodule

// File: tb/tb_board_memory.sv
// Self-checking bench for board_memory: random and directed drops, win writes
// and clears, with drop results checked from an expected queue by a monitor.
module tb_board_memory;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       drop_valid = 1'b0;
    logic       drop_ready;
    logic [2:0] drop_col = '0;
    logic [1:0] drop_player = '0;
    logic       drop_done;
    logic       drop_ok;
    logic [2:0] drop_row;
    logic [2:0] drop_col_q;
    logic [2:0] read_row = '0;
    logic [2:0] read_col = '0;
    logic [1:0] data_out;
    logic       win_we = 1'b0;
    logic [2:0] win_row = '0;
    logic [2:0] win_col = '0;
    logic       board_full;
    logic       busy;

    board_memory #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .drop_valid(drop_valid), .drop_ready(drop_ready),
        .drop_col(drop_col), .drop_player(drop_player),
        .drop_done(drop_done), .drop_ok(drop_ok),
        .drop_row(drop_row), .drop_col_q(drop_col_q),
        .read_row(read_row), .read_col(read_col), .data_out(data_out),
        .win_we(win_we), .win_row(win_row), .win_col(win_col),
        .board_full(board_full), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // {ok, row[2:0], col[2:0]}
    logic [6:0] exp_q[$];

    int ref_cell [8][8];
    int ref_h [8];
    int ref_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) ref_cell[r][c] = 0;
        end
        for (int c = 0; c < 8; c++) ref_h[c] = 0;
        ref_cnt = 0;
    endtask

    function automatic int ref_read(input int r, input int c);
        return (r < ROWS && c < COLS) ? ref_cell[r][c] : 0;
    endfunction

    task automatic set_idle();
        clear = 1'b0;
        drop_valid = 1'b0;
        win_we = 1'b0;
    endtask

    // One IDLE-state cycle: optional drop and optional win write, applied to the model.
    task automatic drive(input bit dv, input int col, input int pl,
                         input bit we, input int wr, input int wc);
        bit ok;
        int row;
        @(negedge clk);
        clear = 1'b0;
        drop_valid = dv;
        drop_col = 3'(col);
        drop_player = 2'(pl);
        win_we = we;
        win_row = 3'(wr);
        win_col = 3'(wc);
        if (dv) begin
            ok = (col < COLS) && (ref_h[col] < ROWS) && (pl == 1 || pl == 2);
            row = ok ? ref_h[col] : 0;
            if (ok) begin
                ref_cell[row][col] = pl;
                ref_h[col]++;
                ref_cnt++;
            end
            exp_q.push_back({ok, 3'(row), 3'(col)});
        end
        if (we && wr < ROWS && wc < COLS) ref_cell[wr][wc] = 3;
    endtask

    task automatic check_read(input int r, input int c);
        @(negedge clk);
        set_idle();
        read_row = 3'(r);
        read_col = 3'(c);
        #1;
        check($sformatf("read(%0d,%0d)", r, c), int'(data_out), ref_read(r, c));
    endtask

    task automatic scan_all();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) check_read(r, c);
        end
    endtask

    task automatic check_status();
        @(negedge clk);
        set_idle();
        #1;
        check("board_full", int'(board_full), int'(ref_cnt == ROWS * COLS));
        check("busy_idle", int'(busy), 0);
        check("drop_ready_idle", int'(drop_ready), 1);
    endtask

    task automatic drain();
        int budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            set_idle();
            budget--;
        end
        check("pending_drop_results", exp_q.size(), 0);
    endtask

    // Starts a sweep with a competing drop and ignored traffic, checking busy/ready per cycle.
    task automatic run_clear();
        @(negedge clk);
        set_idle();
        clear = 1'b1;
        drop_valid = 1'b1;
        drop_col = 3'd2;
        drop_player = 2'b01;
        model_reset();
        for (int i = 0; i < ROWS; i++) begin
            @(negedge clk);
            clear = 1'b1;
            drop_valid = 1'b1;
            win_we = 1'b1;
            win_row = 3'd1;
            win_col = 3'd1;
            #1;
            check($sformatf("busy_sweep%0d", i), int'(busy), 1);
            check($sformatf("drop_ready_sweep%0d", i), int'(drop_ready), 0);
        end
        @(negedge clk);
        set_idle();
        #1;
        check("busy_after_sweep", int'(busy), 0);
        check("drop_ready_after_sweep", int'(drop_ready), 1);
        check("board_full_after_sweep", int'(board_full), 0);
    endtask

    // Monitor: every drop_done must match the oldest expected result.
    always @(posedge clk) begin
        logic [6:0] e;
        #1;
        if (rst_n && drop_done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_drop_done: got drop_done=1, expected none (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("drop_ok", int'(drop_ok), int'(e[6]));
                check("drop_row", int'(drop_row), int'(e[5:3]));
                if (e[6]) check("drop_col_q", int'(drop_col_q), int'(e[2:0]));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_drop_done", int'(drop_done), 0);
        check("rst_drop_ok", int'(drop_ok), 0);
        check("rst_drop_row", int'(drop_row), 0);
        check("rst_drop_col_q", int'(drop_col_q), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_board_full", int'(board_full), 0);
        check("rst_drop_ready", int'(drop_ready), 1);
        rst_n = 1'b1;

        // First drop, then the cell and the one above it.
        drive(1, 3, 1, 0, 0, 0);
        check_read(0, 3);
        check_read(1, 3);

        // Fill column 0 with alternating players, then one too many.
        for (int i = 0; i < ROWS; i++) drive(1, 0, (i % 2 == 0) ? 1 : 2, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0);
        check_read(5, 0);
        check_status();

        // Out-of-range reads return empty.
        check_read(7, 2);
        check_read(2, 7);
        check_read(6, 0);

        // Win writes: in range, out of range, and colliding with a drop.
        drive(0, 0, 0, 1, 2, 2);
        check_read(2, 2);
        drive(0, 0, 0, 1, 6, 1);
        drive(1, 4, 2, 1, 0, 4);
        check_read(0, 4);
        drive(1, 5, 1, 1, 3, 3);
        drain();
        scan_all();

        // Randomized traffic, including illegal columns and player codes.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: drive(1, $urandom_range(0, 7), $urandom_range(0, 3), 0, 0, 0);
                5, 6: drive(0, 0, 0, 1, $urandom_range(0, 7), $urandom_range(0, 7));
                7: drive(1, $urandom_range(0, 7), $urandom_range(1, 2), 1,
                         $urandom_range(0, 7), $urandom_range(0, 7));
                8: drive(0, 0, 0, 0, 0, 0);
                default: check_read($urandom_range(0, 7), $urandom_range(0, 7));
            endcase
        end
        drain();
        scan_all();
        check_status();

        // Clear sweep, then every column lands at row 0 again.
        run_clear();
        scan_all();
        for (int c = 0; c < COLS; c++) drive(1, c, 2, 0, 0, 0);
        drain();
        for (int c = 0; c < COLS; c++) check_read(0, c);

        // Fill the whole board, then one extra drop.
        run_clear();
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) drive(1, c, ((r + c) % 2) + 1, 0, 0, 0);
        end
        drain();
        check_status();
        drive(1, 3, 1, 0, 0, 0);
        drain();
        check_status();

        // Reset on sweep cycle 3 leaves an empty, idle board.
        @(negedge clk);
        set_idle();
        clear = 1'b1;
        repeat (3) begin
            @(negedge clk);
            set_idle();
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_sweep_busy", int'(busy), 0);
        check("rst_mid_sweep_full", int'(board_full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        scan_all();
        check_status();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
